// File: rtl/muladd_ctrl.sv
// muladd_ctrl -- multi-cycle multiply-accumulate controller for madd/msub.
//
// A madd/msub seen in EX (start=1, flush=0) while IDLE latches the operand
// magnitudes, the product sign, the operation and the current HI/LO. The
// unsigned magnitude product is then formed one multiplier bit per cycle
// (MUL, 32 cycles). ACC applies the sign, adds or subtracts the product
// to/from {HI,LO} modulo 2^64 and registers the result. DONE pulses whilo
// for one cycle. While a start is accepted, and through MUL and ACC, the
// PC/IF/ID/EX stages are held.
//
// Optional feature: define MULADD_FAST_EN to replace the shift-add loop with
// a single-cycle 32x32 multiply (MUL lasts one cycle, cnt stays 0). Results
// are identical in both builds.
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   start                 EX stage holds a madd/msub
//   op_sub, op_signed     1=msub / 0=madd; 1=signed operands
//   rs_data, rt_data      multiplicand, multiplier
//   hi_in, lo_in          current (forwarded) HI/LO
//   stallreq_id, flush    ID stall request; pipeline flush
//   stall[5:0]            [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB hold
//   cnt                   shift-add iteration count
//   hilo_tempt            partial/unsigned product
//   whilo                 HI/LO write strobe (DONE only)
//   hi_out, lo_out        result, held until the next ACC
//   busy                  state != IDLE
//   state_dbg             current FSM state (IDLE=0 MUL=1 ACC=2 DONE=3)
//
// Handshake: start is a level, sampled only in IDLE; there is no ready.
// The pipeline is kept stalled by the stall vector instead, and the result
// is valid in the single cycle whilo=1.
module muladd_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        op_sub,
  input  logic        op_signed,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        stallreq_id,
  input  logic        flush,
  output logic [5:0]  stall,
  output logic [4:0]  cnt,
  output logic [63:0] hilo_tempt,
  output logic        whilo,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [31:0] mag_a, mag_b;
  logic        neg_r, sub_r;
  logic [63:0] acc_r;
  logic [63:0] product;
  logic [63:0] acc_result;
  logic        launch;

  assign launch = (state == IDLE) && start && !flush;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state; flush overrides everything
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_nx = MUL;
`ifdef MULADD_FAST_EN
        MUL:  state_nx = ACC;
`else
        MUL:  if (cnt == 5'd31) state_nx = ACC;
`endif
        ACC:  state_nx = DONE;
        DONE: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Sign correction and accumulate, modulo 2^64
  always_comb begin
    product    = neg_r ? (~hilo_tempt + 64'd1) : hilo_tempt;
    acc_result = sub_r ? (acc_r - product) : (acc_r + product);
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mag_a      <= '0;
      mag_b      <= '0;
      neg_r      <= 1'b0;
      sub_r      <= 1'b0;
      acc_r      <= '0;
      cnt        <= '0;
      hilo_tempt <= '0;
      hi_out     <= '0;
      lo_out     <= '0;
    end else if (flush) begin
      cnt        <= '0;
      hilo_tempt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Two's-complement negate of 0x80000000 gives 0x80000000, which
            // read unsigned is exactly the required magnitude 2^31.
            mag_a      <= (op_signed && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
            mag_b      <= (op_signed && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;
            neg_r      <= op_signed && (rs_data[31] ^ rt_data[31]);
            sub_r      <= op_sub;
            acc_r      <= {hi_in, lo_in};
            cnt        <= '0;
            hilo_tempt <= '0;
          end
        end
        MUL: begin
`ifdef MULADD_FAST_EN
          hilo_tempt <= {32'd0, mag_a} * {32'd0, mag_b};
`else
          if (mag_b[cnt])
            hilo_tempt <= hilo_tempt + ({32'd0, mag_a} << cnt);
          // Hold at 31 on the last iteration so cnt never wraps in MUL
          if (cnt != 5'd31)
            cnt <= cnt + 5'd1;
`endif
        end
        ACC: begin
          hi_out <= acc_result[63:32];
          lo_out <= acc_result[31:0];
        end
        default: ;
      endcase
    end
  end

  // Stall vector. MEM/WB are never held. Under reset only the ID request
  // can stall; during a flush nothing stalls.
  always_comb begin
    stall = 6'b000000;
    if (!reset_n) begin
      if (stallreq_id) stall = 6'b000111;
    end else if (flush) begin
      stall = 6'b000000;
    end else if (launch || state == MUL || state == ACC) begin
      stall = 6'b001111;
    end else if (stallreq_id) begin
      stall = 6'b000111;
    end
  end

  assign whilo     = (state == DONE) && !flush;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_muladd_ctrl.sv
// Bench for muladd_ctrl: table of operations with expected {HI,LO}, a
// scoreboard queue popped on whilo, plus flush/reset/stall sequences.
module tb_muladd_ctrl;

`ifdef MULADD_FAST_EN
  localparam int LAT       = 3;
  localparam int FLUSH_C   = 1;
  localparam int FLUSH_CNT = 0;
  localparam int RST_C     = 1;
  localparam int RST_CNT   = 0;
`else
  localparam int LAT       = 34;
  localparam int FLUSH_C   = 11;
  localparam int FLUSH_CNT = 10;
  localparam int RST_C     = 21;
  localparam int RST_CNT   = 20;
`endif

  logic        clk, reset_n, start, op_sub, op_signed, stallreq_id, flush;
  logic [31:0] rs_data, rt_data, hi_in, lo_in;
  logic [5:0]  stall;
  logic [4:0]  cnt;
  logic [63:0] hilo_tempt;
  logic        whilo, busy;
  logic [31:0] hi_out, lo_out;
  logic [1:0]  state_dbg;

  muladd_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_sub(op_sub),
    .op_signed(op_signed), .rs_data(rs_data), .rt_data(rt_data),
    .hi_in(hi_in), .lo_in(lo_in), .stallreq_id(stallreq_id), .flush(flush),
    .stall(stall), .cnt(cnt), .hilo_tempt(hilo_tempt), .whilo(whilo),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sub;
    logic        sgn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] exp;
    logic        hold;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  vec_t        vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic sub, input logic sgn,
                                        input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] p;
    if (sgn) p = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    else     p = {32'd0, rs} * {32'd0, rt};
    return sub ? ({hi, lo} - p) : ({hi, lo} + p);
  endfunction

  function automatic vec_t mk(input logic sub, input logic sgn, input logic [31:0] rs,
                              input logic [31:0] rt, input logic [31:0] hi,
                              input logic [31:0] lo, input logic [63:0] exp,
                              input logic hold);
    vec_t v;
    v.sub = sub; v.sgn = sgn; v.rs = rs; v.rt = rt; v.hi = hi; v.lo = lo;
    v.exp = exp; v.hold = hold;
    return v;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are checked on
  // the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v);
    logic [63:0] e;
    step();
    start = 1'b1; op_sub = v.sub; op_signed = v.sgn;
    rs_data = v.rs; rt_data = v.rt; hi_in = v.hi; lo_in = v.lo;
    stallreq_id = 1'b0;
    exp_q.push_back(v.exp);
    @(negedge clk);
    chk("stall_launch", 64'(stall), 64'(6'b001111));
    chk("busy_launch", 64'(busy), 64'd0);
    for (int c = 1; c <= LAT; c++) begin
      step();
      // Operands must have been latched: scramble the live inputs.
      rs_data = $urandom(); rt_data = $urandom(); hi_in = $urandom(); lo_in = $urandom();
      op_sub = ~v.sub; op_signed = ~v.sgn;
      if (!v.hold) start = 1'b0;
      stallreq_id = v.hold;
      @(negedge clk);
      if (c < LAT) begin
        chk("stall_busy", 64'(stall), 64'(6'b001111));
        chk("whilo_early", 64'(whilo), 64'd0);
        chk("busy_run", 64'(busy), 64'd1);
`ifndef MULADD_FAST_EN
        chk("cnt_run", 64'(cnt), 64'((c <= 32) ? c - 1 : 31));
`endif
      end else begin
        chk("whilo_done", 64'(whilo), 64'd1);
        chk("stall_done", 64'(stall), v.hold ? 64'(6'b000111) : 64'd0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (whilo) chk("result", {hi_out, lo_out}, e);
        end
      end
    end
    step();
    start = 1'b0; stallreq_id = 1'b0;
    @(negedge clk);
    chk("whilo_after", 64'(whilo), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    chk("result_held", {hi_out, lo_out}, v.exp);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op_sub = 1'b0; op_signed = 1'b0;
    rs_data = '0; rt_data = '0; hi_in = '0; lo_in = '0;
    stallreq_id = 1'b0; flush = 1'b0;

    vecs[0] = mk(0, 0, 32'd3,        32'd5,        32'd0,        32'd10,       64'h0000_0000_0000_0019, 0);
    vecs[1] = mk(1, 1, 32'hFFFFFFFE, 32'd3,        32'd0,        32'd0,        64'h0000_0000_0000_0006, 1);
    vecs[2] = mk(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFF_FFFE_0000_0000, 0);
    vecs[3] = mk(0, 1, 32'h80000000, 32'd1,        32'd0,        32'd0,        64'hFFFF_FFFF_8000_0000, 1);
    vecs[4] = mk(0, 1, 32'h80000000, 32'h80000000, 32'd0,        32'd0,        64'h4000_0000_0000_0000, 0);
    vecs[5] = mk(1, 0, 32'd2,        32'd3,        32'd0,        32'd5,        64'hFFFF_FFFF_FFFF_FFFF, 0);
    vecs[6] = mk(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 64'h0000_0001_0000_0000, 1);
    for (int i = 7; i < 13; i++) begin
      logic        s, g;
      logic [31:0] a, b, h, l;
      s = 1'($urandom_range(0, 1)); g = 1'($urandom_range(0, 1));
      a = $urandom(); b = $urandom(); h = $urandom(); l = $urandom();
      vecs[i] = mk(s, g, a, b, h, l, model(s, g, a, b, h, l), 1'(i % 2));
    end

    // Reset state, including stall behaviour while reset is held
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_whilo", 64'(whilo), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_hilo_tempt", hilo_tempt, 64'd0);
    chk("rst_result", {hi_out, lo_out}, 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    start = 1'b1; stallreq_id = 1'b1; #1;
    chk("rst_stall_id", 64'(stall), 64'(6'b000111));
    start = 1'b0; stallreq_id = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Table-driven operations
    for (int i = 0; i < 13; i++) run_op(vecs[i]);

    // ID stall only, and flush+start together in IDLE
    step();
    stallreq_id = 1'b1;
    @(negedge clk);
    chk("stall_id_only", 64'(stall), 64'(6'b000111));
    step();
    start = 1'b1; flush = 1'b1; rs_data = 32'd7; rt_data = 32'd7;
    @(negedge clk);
    chk("stall_flush_start", 64'(stall), 64'd0);
    step();
    start = 1'b0; flush = 1'b0; stallreq_id = 1'b0;
    @(negedge clk);
    chk("busy_flush_start", 64'(busy), 64'd0);

    // Flush mid-operation
    step();
    start = 1'b1; op_sub = 1'b0; op_signed = 1'b0;
    rs_data = 32'd3; rt_data = 32'd5; hi_in = 32'd0; lo_in = 32'd10;
    for (int c = 1; c <= FLUSH_C; c++) begin
      step();
      start = 1'b0;
      if (c == FLUSH_C) flush = 1'b1;
    end
    @(negedge clk);
    chk("flush_cnt", 64'(cnt), 64'(FLUSH_CNT));
    chk("flush_stall", 64'(stall), 64'd0);
    chk("flush_whilo", 64'(whilo), 64'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_cnt_clr", 64'(cnt), 64'd0);
    chk("flush_tempt_clr", hilo_tempt, 64'd0);
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      chk("flush_no_whilo", 64'(whilo), 64'd0);
    end

    // Reset mid-operation
    step();
    start = 1'b1; op_sub = 1'b0; op_signed = 1'b0;
    rs_data = 32'd9; rt_data = 32'd9; hi_in = 32'd1; lo_in = 32'd1;
    for (int c = 1; c <= RST_C; c++) begin
      step();
      start = 1'b0;
    end
    @(negedge clk);
    chk("pre_rst_cnt", 64'(cnt), 64'(RST_CNT));
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_cnt", 64'(cnt), 64'd0);
    chk("mid_rst_tempt", hilo_tempt, 64'd0);
    chk("mid_rst_result", {hi_out, lo_out}, 64'd0);
    chk("mid_rst_whilo", 64'(whilo), 64'd0);
    chk("mid_rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      chk("rst_no_whilo", 64'(whilo), 64'd0);
      chk("rst_idle", 64'(busy), 64'd0);
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
